// File: rtl/regfile_pkg.sv
// Shared register-file constants and the address-to-enable decode used by the write arbiter.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int ZERO_REG   = 31;

  // Register 31 is hard-wired to zero, so its enable is never produced.
  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
    addr_onehot = '0;
    if (addr != REG_ADDR_W'(ZERO_REG)) addr_onehot[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   ptr,
  output logic               valid,
  output logic [PTR_W-1:0]   winner
);

  // Scan from the far end so the last hit written is the nearest one to ptr.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (eligible[idx]) begin
        valid  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register file's single write port; all outputs are registered.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req,
  input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]        req_data,
  output logic [NUM_REQ-1:0]                    grant,
  output logic [NUM_REGS-1:0]                   wr_en,
  output logic [DATA_W-1:0]                     wr_data,
  output logic                                  busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Handshake: req[i] with req_addr[i]/req_data[i] is a valid+payload that must stay
  // stable until grant[i] is seen high; that grant cycle is the transfer cycle, and a
  // requester still holding req afterwards competes again one edge later.

  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  eligible;
  logic                pick_valid;
  logic [PTR_W-1:0]    pick_winner;

  assign eligible = req & ~grant_q;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .eligible (eligible),
    .ptr      (ptr_q),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

  always_comb begin
    grant_d   = '0;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    busy_d    = 1'b0;
    if (pick_valid) begin
      grant_d[pick_winner] = 1'b1;
      wr_en_d              = addr_onehot(req_addr[pick_winner]);
      wr_data_d            = req_data[pick_winner];
      busy_d               = 1'b1;
      ptr_d                = (pick_winner == PTR_W'(NUM_REQ - 1)) ? '0 : pick_winner + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q   <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
    end
  end

  assign grant   = grant_q;
  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

  localparam int TESTBENCH_DELAY = 5;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;

  logic                           clk;
  logic                           reset;
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][4:0]        req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             grant;
  logic [31:0]                    wr_en;
  logic [DATA_W-1:0]              wr_data;
  logic                           busy;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .grant    (grant),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #(TESTBENCH_DELAY) clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [31:0] en,
                           input logic [63:0] d);
    check_eq({tag, ".grant"},   64'(grant),   64'(g));
    check_eq({tag, ".wr_en"},   64'(wr_en),   64'(en));
    check_eq({tag, ".wr_data"}, wr_data,      d);
    check_eq({tag, ".busy"},    64'(busy),    64'(|g));
  endtask

  logic [63:0] last_data;
  logic [3:0]  exp_g;

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    #2;
    check_out("reset", 4'b0000, 32'h0, 64'h0);
    check_eq("reset.ptr", 64'(dut.ptr_q), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // Mid-cycle reset while grant[2] / wr_en[7] are live
    req[2] = 1'b1; req_addr[2] = 5'd7; req_data[2] = 64'h1234;
    tick();
    check_out("pre_rst", 4'b0100, 32'h80, 64'h1234);
    req[2] = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_out("async_rst", 4'b0000, 32'h0, 64'h0);
    reset = 1'b0;
    check_eq("async_rst.ptr", 64'(dut.ptr_q), 64'd0);
    tick();

    // Single requester held high: grant every other edge
    req[1] = 1'b1; req_addr[1] = 5'd5; req_data[1] = 64'hAA;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_g = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      check_out($sformatf("single%0d", k), exp_g, (k % 2 == 0) ? 32'h20 : 32'h0, 64'hAA);
    end
    req = '0;
    tick();
    pulse_reset();

    // All four requesters, ptr = 0, addrs 1..4
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i] = 5'(i + 1);
      req_data[i] = 64'h100 + 64'(i);
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int w;
      w = k % NUM_REQ;
      tick();
      check_out($sformatf("all%0d", k), 4'(1 << w), 32'(1) << (w + 1), 64'h100 + 64'(w));
    end
    req = '0;
    tick();

    // Zero-register target: grant issued, write dropped, ptr wraps to 0
    req[3] = 1'b1; req_addr[3] = 5'd31; req_data[3] = 64'hFF;
    tick();
    check_out("zero_reg", 4'b1000, 32'h0, 64'hFF);
    check_eq("zero_reg.ptr", 64'(dut.ptr_q), 64'd0);
    req[3] = 1'b0;
    tick();

    // Bring ptr to 1, then req[0] and req[2] together
    req[0] = 1'b1; req_addr[0] = 5'd9; req_data[0] = 64'hDEAD_0000;
    tick();
    req[0] = 1'b0;
    tick();
    check_eq("setup.ptr", 64'(dut.ptr_q), 64'd1);
    req[2] = 1'b1; req_addr[2] = 5'd12; req_data[2] = 64'hBEEF_0002;
    req[0] = 1'b1;
    tick();
    check_out("pair0", 4'b0100, 32'h1000, 64'hBEEF_0002);
    req[2] = 1'b0;
    tick();
    check_out("pair1", 4'b0001, 32'h200, 64'hDEAD_0000);
    req[0] = 1'b0;
    check_eq("pair.ptr", 64'(dut.ptr_q), 64'd1);
    last_data = 64'hDEAD_0000;

    // Idle: outputs quiet, data and ptr held
    for (int k = 0; k < 5; k++) begin
      tick();
      check_out($sformatf("idle%0d", k), 4'b0000, 32'h0, last_data);
      check_eq($sformatf("idle%0d.ptr", k), 64'(dut.ptr_q), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
